// File: rtl/hdmi_timing_pkg.sv
// Shared timing types and constants for the TMDS period sequencer and lane mux.
// Latency: n/a (types and constants only).
// Backpressure: none; the raster is free-running and never stalls.
//
// Contents:
//   period_t            - what the TMDS lanes transmit in a given pixel cycle
//   CTL_VIDEO_PREAMBLE  - {CTL3,CTL2,CTL1,CTL0} announcing a video data period
//   GB_VIDEO_LANE0/1/2  - 10-bit video guard-band words substituted by the lane mux

package hdmi_timing_pkg;

    typedef enum logic [1:0] {
        PER_CONTROL  = 2'd0,
        PER_PREAMBLE = 2'd1,
        PER_GUARD    = 2'd2,
        PER_VIDEO    = 2'd3
    } period_t;

    // CTL0=1, others 0: video data period follows.
    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;

    // Video guard-band characters. Lanes 0 and 2 share a word; lane 1 is its complement.
    localparam logic [9:0] GB_VIDEO_LANE0 = 10'b1011001100;
    localparam logic [9:0] GB_VIDEO_LANE1 = 10'b0100110011;
    localparam logic [9:0] GB_VIDEO_LANE2 = 10'b1011001100;

endpackage

// File: rtl/hv_counter.sv
// Raster position counters with wrap, look-ahead next_active flag and new_frame pulse.
// Latency: hcount/vcount/new_frame registered (1 cycle); *_nxt outputs are the values loaded at the next edge.
// Backpressure: none; advances every clock cycle.
//
// Ports:
//   clk_in, rst_in        pixel clock, synchronous active-high reset
//   hcount_out/vcount_out current registered raster position
//   hcount_nxt_out/...    position that will be shown next cycle, so that the parent can
//                         register decoded flags aligned with hcount_out/vcount_out
//   next_active_nxt_out   the line after vcount_nxt is an active line
//   new_frame_nxt_out     next position is (0,0)
//   new_frame_out         registered pulse, high while (0,0) is shown

module hv_counter #(
    parameter int H_ACTIVE = 1280,
    parameter int H_TOTAL  = 1650,
    parameter int V_ACTIVE = 720,
    parameter int V_TOTAL  = 750
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [10:0] hcount_nxt_out,
    output logic [9:0]  vcount_nxt_out,
    output logic        next_active_nxt_out,
    output logic        new_frame_nxt_out,
    output logic        new_frame_out
);

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_RST      = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_LAST_ACT = 10'(V_ACTIVE - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        new_frame_q, new_frame_d;
    logic        next_active_d;

    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = 11'd0;
            vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
        end
        new_frame_d = (hcount_d == 11'd0) && (vcount_d == 10'd0);
        // The last blanking line counts because the line after it is line 0.
        next_active_d = (vcount_d == V_LAST) || (vcount_d < V_LAST_ACT);
    end

    // Reset parks the raster in the blanking of the last line, ahead of the
    // preamble, so the first frame after reset is framed like any other.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hcount_q    <= H_RST;
            vcount_q    <= V_LAST;
            new_frame_q <= 1'b0;
        end else begin
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            new_frame_q <= new_frame_d;
        end
    end

    assign hcount_out          = hcount_q;
    assign vcount_out          = vcount_q;
    assign hcount_nxt_out      = rst_in ? H_RST  : hcount_d;
    assign vcount_nxt_out      = rst_in ? V_LAST : vcount_d;
    assign next_active_nxt_out = rst_in ? 1'b1   : next_active_d;
    assign new_frame_nxt_out   = rst_in ? 1'b0   : new_frame_d;
    assign new_frame_out       = new_frame_q;

endmodule

// File: rtl/tmds_period_sequencer.sv
// Raster timing generator and HDMI/DVI period scheduler for the three TMDS encoder lanes.
// Latency: all outputs registered and mutually aligned with hcount_out/vcount_out.
// Backpressure: none; free-running at the pixel clock.
//
// Ports:
//   clk_in, rst_in       pixel clock, synchronous active-high reset
//   hcount_out/vcount_out raster position
//   hsync_out/vsync_out  active-high syncs (vsync is line based, changes at hcount 0)
//   ve_out               active video, to every encoder ve_in
//   guard_out            video guard-band cycle, lane mux substitutes the guard word
//   ctl_out              {CTL3..CTL0} for the control_in of lanes 1 and 2
//   period_out           period_t of the current cycle
//   new_frame_out        1-cycle pulse while (0,0) is shown
//   frame_count_out      frames started since reset, wraps 255 -> 0

module tmds_period_sequencer
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter bit HDMI_MODE = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        ve_out,
    output logic        guard_out,
    output logic [3:0]  ctl_out,
    output logic [1:0]  period_out,
    output logic        new_frame_out,
    output logic [7:0]  frame_count_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    // Preamble is 8 cycles, guard band is the final 2 cycles of the line.
    localparam logic [10:0] PRE_START = 11'(H_TOTAL - 10);
    localparam logic [10:0] PRE_END   = 11'(H_TOTAL - 3);
    localparam logic [10:0] GB_START  = 11'(H_TOTAL - 2);
    localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount_nxt;
    logic [9:0]  vcount_nxt;
    logic        next_active_nxt;
    logic        new_frame_nxt;

    hv_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) u_hv_counter (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .hcount_out          (hcount_out),
        .vcount_out          (vcount_out),
        .hcount_nxt_out      (hcount_nxt),
        .vcount_nxt_out      (vcount_nxt),
        .next_active_nxt_out (next_active_nxt),
        .new_frame_nxt_out   (new_frame_nxt),
        .new_frame_out       (new_frame_out)
    );

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        ve_q, ve_d;
    logic        guard_q, guard_d;
    logic        preamble_d;
    logic [3:0]  ctl_q, ctl_d;
    period_t     period_q, period_d;
    logic [7:0]  frame_count_q, frame_count_d;

    // Everything is decoded from the position about to be loaded, so the
    // registered flags line up with the registered counters.
    always_comb begin
        hsync_d    = (hcount_nxt >= HS_START) && (hcount_nxt < HS_END);
        vsync_d    = (vcount_nxt >= VS_START) && (vcount_nxt < VS_END);
        ve_d       = (hcount_nxt < H_ACT) && (vcount_nxt < V_ACT);
        preamble_d = HDMI_MODE && next_active_nxt &&
                     (hcount_nxt >= PRE_START) && (hcount_nxt <= PRE_END);
        guard_d    = HDMI_MODE && next_active_nxt && (hcount_nxt >= GB_START);

        period_d = PER_CONTROL;
        if (guard_d) begin
            period_d = PER_GUARD;
        end else if (preamble_d) begin
            period_d = PER_PREAMBLE;
        end else if (ve_d) begin
            period_d = PER_VIDEO;
        end

        ctl_d         = preamble_d ? CTL_VIDEO_PREAMBLE : 4'b0000;
        frame_count_d = frame_count_q + {7'd0, new_frame_nxt};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            ve_q          <= 1'b0;
            guard_q       <= 1'b0;
            ctl_q         <= 4'b0000;
            period_q      <= PER_CONTROL;
            frame_count_q <= 8'd0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            ve_q          <= ve_d;
            guard_q       <= guard_d;
            ctl_q         <= ctl_d;
            period_q      <= period_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign hsync_out       = hsync_q;
    assign vsync_out       = vsync_q;
    assign ve_out          = ve_q;
    assign guard_out       = guard_q;
    assign ctl_out         = ctl_q;
    assign period_out      = period_q;
    assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_tmds_period_sequencer.sv
module tb_tmds_period_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;   // default-parameter instance
    logic rst_s = 1'b1;   // small HDMI and small DVI instances

    // sel 0: defaults, sel 1: small HDMI, sel 2: small DVI
    logic [10:0] h0, h1, h2;
    logic [9:0]  v0, v1, v2;
    logic        hs0, hs1, hs2, vs0, vs1, vs2, ve0, ve1, ve2, gd0, gd1, gd2;
    logic        nf0, nf1, nf2;
    logic [3:0]  ctl0, ctl1, ctl2;
    logic [1:0]  per0, per1, per2;
    logic [7:0]  fc0, fc1, fc2;

    tmds_period_sequencer u_dut_def (
        .clk_in(clk), .rst_in(rst_d), .hcount_out(h0), .vcount_out(v0),
        .hsync_out(hs0), .vsync_out(vs0), .ve_out(ve0), .guard_out(gd0),
        .ctl_out(ctl0), .period_out(per0), .new_frame_out(nf0), .frame_count_out(fc0));

    tmds_period_sequencer #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(10),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HDMI_MODE(1'b1)
    ) u_dut_small (
        .clk_in(clk), .rst_in(rst_s), .hcount_out(h1), .vcount_out(v1),
        .hsync_out(hs1), .vsync_out(vs1), .ve_out(ve1), .guard_out(gd1),
        .ctl_out(ctl1), .period_out(per1), .new_frame_out(nf1), .frame_count_out(fc1));

    tmds_period_sequencer #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(10),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HDMI_MODE(1'b0)
    ) u_dut_dvi (
        .clk_in(clk), .rst_in(rst_s), .hcount_out(h2), .vcount_out(v2),
        .hsync_out(hs2), .vsync_out(vs2), .ve_out(ve2), .guard_out(gd2),
        .ctl_out(ctl2), .period_out(per2), .new_frame_out(nf2), .frame_count_out(fc2));

    typedef struct {
        int h, v, hs, vs, ve, gd, ctl, per, nf, fc;
    } obs_t;

    typedef struct {
        int sel, h, v, hs, vs, ve, gd, ctl, per;
    } vec_t;

    localparam int P_CTL = 0, P_PRE = 1, P_GRD = 2, P_VID = 3;
    localparam int SMALL_FRAME = 22 * 7;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic snap(input int sel, output obs_t o);
        case (sel)
            0: o = '{int'(h0), int'(v0), int'(hs0), int'(vs0), int'(ve0), int'(gd0),
                     int'(ctl0), int'(per0), int'(nf0), int'(fc0)};
            1: o = '{int'(h1), int'(v1), int'(hs1), int'(vs1), int'(ve1), int'(gd1),
                     int'(ctl1), int'(per1), int'(nf1), int'(fc1)};
            default: o = '{int'(h2), int'(v2), int'(hs2), int'(vs2), int'(ve2), int'(gd2),
                           int'(ctl2), int'(per2), int'(nf2), int'(fc2)};
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int sel, input int h, input int v, input int budget,
                            output bit ok);
        obs_t o;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            snap(sel, o);
            if (o.h == h && o.v == v) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic add(input int sel, input int h, input int v, input int hs, input int vs,
                       input int ve, input int gd, input int ctl, input int per);
        vec_t t;
        t.sel = sel; t.h = h; t.v = v; t.hs = hs; t.vs = vs;
        t.ve = ve; t.gd = gd; t.ctl = ctl; t.per = per;
        vecs.push_back(t);
    endtask

    task automatic chk_reset(input int sel, input int h, input int v);
        obs_t o;
        snap(sel, o);
        chk($sformatf("rst%0d_h", sel), o.h, h);
        chk($sformatf("rst%0d_v", sel), o.v, v);
        chk($sformatf("rst%0d_fc", sel), o.fc, 0);
        chk($sformatf("rst%0d_flags", sel), o.hs + o.vs + o.ve + o.gd + o.nf + o.ctl, 0);
        chk($sformatf("rst%0d_per", sel), o.per, P_CTL);
    endtask

    initial begin
        obs_t o, od, prev;
        bit ok;
        int n, pulses, last_fc;

        // sel h v  hs vs ve gd ctl per   (default params, in raster order after reset)
        add(0, 1639, 749, 0, 0, 0, 0, 0, P_CTL);
        add(0, 1640, 749, 0, 0, 0, 0, 1, P_PRE);
        add(0, 1647, 749, 0, 0, 0, 0, 1, P_PRE);
        add(0, 1648, 749, 0, 0, 0, 1, 0, P_GRD);
        add(0, 1649, 749, 0, 0, 0, 1, 0, P_GRD);
        add(0,    0,   0, 0, 0, 1, 0, 0, P_VID);
        add(0, 1279,   0, 0, 0, 1, 0, 0, P_VID);
        add(0, 1280,   0, 0, 0, 0, 0, 0, P_CTL);
        add(0, 1389,   0, 0, 0, 0, 0, 0, P_CTL);
        add(0, 1390,   0, 1, 0, 0, 0, 0, P_CTL);
        add(0, 1429,   0, 1, 0, 0, 0, 0, P_CTL);
        add(0, 1430,   0, 0, 0, 0, 0, 0, P_CTL);
        add(0, 1640,   0, 0, 0, 0, 0, 1, P_PRE);
        add(0, 1649,   0, 0, 0, 0, 1, 0, P_GRD);
        add(0,    0,   1, 0, 0, 1, 0, 0, P_VID);
        // small params: H_TOTAL 22, V_TOTAL 7, last active line 3
        add(1,    0,   3, 0, 0, 1, 0, 0, P_VID);
        add(1,    7,   1, 0, 0, 1, 0, 0, P_VID);
        add(1,   11,   1, 1, 0, 0, 0, 0, P_CTL);
        add(1,   12,   2, 0, 0, 0, 0, 1, P_PRE);
        add(1,   20,   2, 0, 0, 0, 1, 0, P_GRD);
        add(1,   12,   3, 0, 0, 0, 0, 0, P_CTL);
        add(1,   21,   3, 0, 0, 0, 0, 0, P_CTL);
        add(1,   21,   4, 0, 0, 0, 0, 0, P_CTL);
        add(1,    0,   5, 0, 1, 0, 0, 0, P_CTL);
        add(1,   10,   5, 1, 1, 0, 0, 0, P_CTL);
        add(1,   21,   5, 0, 1, 0, 0, 0, P_CTL);
        add(1,    0,   6, 0, 0, 0, 0, 0, P_CTL);
        add(1,   12,   6, 0, 0, 0, 0, 1, P_PRE);
        add(1,   21,   6, 0, 0, 0, 1, 0, P_GRD);

        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (3) step();
        chk_reset(0, 1280, 749);
        chk_reset(1, 8, 6);
        chk_reset(2, 8, 6);

        // First active pixel after reset release: 1650 - 1280 = 370 cycles.
        rst_d = 1'b0;
        rst_s = 1'b0;
        n = 0;
        for (int i = 1; i <= 2000; i++) begin
            step();
            if (ve0) begin
                n = i;
                break;
            end
        end
        chk("first_ve_delay", n, 370);
        snap(0, o);
        chk("first_ve_h", o.h, 0);
        chk("first_ve_v", o.v, 0);
        chk("first_ve_new_frame", o.nf, 1);
        chk("first_ve_frame_count", o.fc, 1);
        step();
        snap(0, o);
        chk("new_frame_one_cycle", o.nf, 0);

        // One-cycle reset in the middle of a line.
        wait_pos(0, 600, 1, 5000, ok);
        chk("reach_600_1", int'(ok), 1);
        rst_d = 1'b1;
        step();
        rst_d = 1'b0;
        chk_reset(0, 1280, 749);

        foreach (vecs[k]) begin
            wait_pos(vecs[k].sel, vecs[k].h, vecs[k].v,
                     (vecs[k].sel == 0) ? 4000 : 2 * SMALL_FRAME, ok);
            chk($sformatf("vec%0d_reached", k), int'(ok), 1);
            snap(vecs[k].sel, o);
            chk($sformatf("vec%0d_hs", k), o.hs, vecs[k].hs);
            chk($sformatf("vec%0d_vs", k), o.vs, vecs[k].vs);
            chk($sformatf("vec%0d_ve", k), o.ve, vecs[k].ve);
            chk($sformatf("vec%0d_gd", k), o.gd, vecs[k].gd);
            chk($sformatf("vec%0d_ctl", k), o.ctl, vecs[k].ctl);
            chk($sformatf("vec%0d_per", k), o.per, vecs[k].per);
        end

        // Small HDMI vs small DVI over two frames from reset.
        rst_s = 1'b1;
        repeat (2) step();
        rst_s = 1'b0;
        snap(1, prev);
        pulses = 0;
        for (int i = 0; i < 2 * SMALL_FRAME; i++) begin
            step();
            snap(1, o);
            snap(2, od);
            chk("dvi_ve_matches", od.ve, o.ve);
            chk("dvi_h_matches", od.h, o.h);
            chk("dvi_guard_zero", od.gd, 0);
            chk("dvi_ctl_zero", od.ctl, 0);
            chk("dvi_period", od.per, od.ve ? P_VID : P_CTL);
            if (o.vs != prev.vs) chk("vsync_changes_at_h0", o.h, 0);
            if (o.nf == 1) begin
                pulses++;
                chk("new_frame_at_origin", o.h + o.v, 0);
            end
            prev = o;
        end
        chk("small_pulses", pulses, 2);
        chk("small_frame_count", fc1, 2);

        // Frame counter wrap 255 -> 0 on the 256th frame start.
        last_fc = int'(fc1);
        ok = 1'b0;
        for (int i = 0; i < 260 * SMALL_FRAME; i++) begin
            step();
            if (nf1) begin
                pulses++;
                if (pulses == 256) begin
                    chk("fc_before_wrap", last_fc, 255);
                    chk("fc_wrap", fc1, 0);
                    ok = 1'b1;
                    break;
                end
            end
            last_fc = int'(fc1);
        end
        chk("fc_wrap_reached", int'(ok), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
